// File: rtl/sc_level_progress_tracker_if.sv
// ============================================================================
// Module   : sc_level_progress_tracker_if
// Brief    : Signal bundle between the level state machine / playfield logic
//            and the level progress tracker.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface sc_level_progress_tracker_if #(
  parameter int CURRENT_LEVEDATAWIDTH = 3,
  parameter int PROGRESS_DATAWIDTH    = 5
);
  logic                             SC_LEVEL_PROGRESS_FrogArrived_InLow;
  logic                             SC_LEVEL_PROGRESS_StartCount_In;
  logic                             SC_LEVEL_PROGRESS_LevelFinished_In;
  logic                             SC_LEVEL_PROGRESS_FinishedGame_In;
  logic [CURRENT_LEVEDATAWIDTH-1:0] SC_LEVEL_PROGRESS_CurrentLevel_Out;
  logic [PROGRESS_DATAWIDTH-1:0]    SC_LEVEL_PROGRESS_LvlProgressCount_Out;
  logic                             SC_LEVEL_PROGRESS_GoalReached_Out;

  modport master (
    output SC_LEVEL_PROGRESS_FrogArrived_InLow,
    output SC_LEVEL_PROGRESS_StartCount_In,
    output SC_LEVEL_PROGRESS_LevelFinished_In,
    output SC_LEVEL_PROGRESS_FinishedGame_In,
    input  SC_LEVEL_PROGRESS_CurrentLevel_Out,
    input  SC_LEVEL_PROGRESS_LvlProgressCount_Out,
    input  SC_LEVEL_PROGRESS_GoalReached_Out
  );

  modport slave (
    input  SC_LEVEL_PROGRESS_FrogArrived_InLow,
    input  SC_LEVEL_PROGRESS_StartCount_In,
    input  SC_LEVEL_PROGRESS_LevelFinished_In,
    input  SC_LEVEL_PROGRESS_FinishedGame_In,
    output SC_LEVEL_PROGRESS_CurrentLevel_Out,
    output SC_LEVEL_PROGRESS_LvlProgressCount_Out,
    output SC_LEVEL_PROGRESS_GoalReached_Out
  );
endinterface

`default_nettype wire

// File: rtl/sc_level_progress_tracker.sv
// ============================================================================
// Module   : sc_level_progress_tracker
// Brief    : Counts frog crossings per level, flags the level goal and
//            advances/freezes the level on state-machine request.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sc_level_progress_tracker #(
  parameter int CURRENT_LEVEDATAWIDTH = 3,
  parameter int PROGRESS_DATAWIDTH    = 5,
  parameter int GOAL_LEVEL_1          = 5,
  parameter int GOAL_LEVEL_2          = 8,
  parameter int GOAL_LEVEL_3          = 12,
  parameter int MAX_LEVEL             = 3
) (
  input wire logic                   SC_LEVEL_PROGRESS_CLOCK_50,
  input wire logic                   SC_LEVEL_PROGRESS_RESET_InHigh,
  sc_level_progress_tracker_if.slave bus
);

  localparam logic [CURRENT_LEVEDATAWIDTH-1:0] c_LVL_0    = '0;
  localparam logic [CURRENT_LEVEDATAWIDTH-1:0] c_LVL_1    = CURRENT_LEVEDATAWIDTH'(1);
  localparam logic [CURRENT_LEVEDATAWIDTH-1:0] c_LVL_2    = CURRENT_LEVEDATAWIDTH'(2);
  localparam logic [CURRENT_LEVEDATAWIDTH-1:0] c_LVL_3    = CURRENT_LEVEDATAWIDTH'(3);
  localparam logic [CURRENT_LEVEDATAWIDTH-1:0] c_LVL_MAX  = CURRENT_LEVEDATAWIDTH'(MAX_LEVEL);
  localparam logic [PROGRESS_DATAWIDTH-1:0]    c_GOAL_1   = PROGRESS_DATAWIDTH'(GOAL_LEVEL_1);
  localparam logic [PROGRESS_DATAWIDTH-1:0]    c_GOAL_2   = PROGRESS_DATAWIDTH'(GOAL_LEVEL_2);
  localparam logic [PROGRESS_DATAWIDTH-1:0]    c_GOAL_3   = PROGRESS_DATAWIDTH'(GOAL_LEVEL_3);
  localparam logic [PROGRESS_DATAWIDTH-1:0]    c_CNT_MAX  = '1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_COUNTING = 3'd1,
    ST_GOAL     = 3'd2,
    ST_ADVANCE  = 3'd3,
    ST_FROZEN   = 3'd4
  } state_t;

  state_t                           r_state,  w_state_nxt;
  logic                             r_arrival;
  logic [CURRENT_LEVEDATAWIDTH-1:0] r_level,  w_level_nxt;
  logic [PROGRESS_DATAWIDTH-1:0]    r_count,  w_count_nxt;
  logic                             r_goal,   w_goal_nxt;
  logic [PROGRESS_DATAWIDTH-1:0]    w_goal_val;
  logic [PROGRESS_DATAWIDTH-1:0]    w_count_inc;
  logic                             w_edge;

  // Falling edge of the active-low arrival line marks one crossing.
  assign w_edge = r_arrival & ~bus.SC_LEVEL_PROGRESS_FrogArrived_InLow;

  always_comb begin
    w_goal_val = c_GOAL_3;
    case (r_level)
      c_LVL_1: w_goal_val = c_GOAL_1;
      c_LVL_2: w_goal_val = c_GOAL_2;
      c_LVL_3: w_goal_val = c_GOAL_3;
      default: w_goal_val = c_GOAL_3;
    endcase
  end

  assign w_count_inc = (r_count == c_CNT_MAX) ? r_count : r_count + 1'b1;

  always_ff @(posedge SC_LEVEL_PROGRESS_CLOCK_50) begin
    if (SC_LEVEL_PROGRESS_RESET_InHigh) begin
      r_state   <= ST_IDLE;
      r_arrival <= 1'b1;
      r_level   <= c_LVL_0;
      r_count   <= '0;
      r_goal    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_arrival <= bus.SC_LEVEL_PROGRESS_FrogArrived_InLow;
      r_level   <= w_level_nxt;
      r_count   <= w_count_nxt;
      r_goal    <= w_goal_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_level_nxt = r_level;
    w_count_nxt = r_count;
    w_goal_nxt  = r_goal;
    if (bus.SC_LEVEL_PROGRESS_FinishedGame_In) begin
      w_state_nxt = ST_FROZEN;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.SC_LEVEL_PROGRESS_StartCount_In) begin
            w_state_nxt = ST_COUNTING;
            w_level_nxt = (r_level == c_LVL_0) ? c_LVL_1 : r_level;
            w_count_nxt = '0;
          end
        end
        ST_COUNTING: begin
          if (!bus.SC_LEVEL_PROGRESS_StartCount_In) begin
            w_state_nxt = ST_IDLE;
          end else if (w_edge) begin
            w_count_nxt = w_count_inc;
            if (w_count_inc == w_goal_val) begin
              w_state_nxt = ST_GOAL;
              w_goal_nxt  = 1'b1;
            end
          end
        end
        ST_GOAL: begin
          if (bus.SC_LEVEL_PROGRESS_LevelFinished_In) begin
            w_state_nxt = ST_ADVANCE;
          end
        end
        ST_ADVANCE: begin
          w_count_nxt = '0;
          w_goal_nxt  = 1'b0;
          w_level_nxt = r_level + 1'b1;
          w_state_nxt = (r_level == c_LVL_MAX) ? ST_FROZEN : ST_IDLE;
        end
        ST_FROZEN: begin
          w_state_nxt = ST_FROZEN;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  assign bus.SC_LEVEL_PROGRESS_CurrentLevel_Out     = r_level;
  assign bus.SC_LEVEL_PROGRESS_LvlProgressCount_Out = r_count;
  assign bus.SC_LEVEL_PROGRESS_GoalReached_Out      = r_goal;

endmodule

`default_nettype wire

// File: tb/tb_sc_level_progress_tracker.sv
// ============================================================================
// Module   : tb_sc_level_progress_tracker
// Brief    : Directed self-checking bench for sc_level_progress_tracker.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sc_level_progress_tracker;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  sc_level_progress_tracker_if #(
    .CURRENT_LEVEDATAWIDTH(3),
    .PROGRESS_DATAWIDTH   (5)
  ) bus ();

  sc_level_progress_tracker #(
    .CURRENT_LEVEDATAWIDTH(3),
    .PROGRESS_DATAWIDTH   (5),
    .GOAL_LEVEL_1         (5),
    .GOAL_LEVEL_2         (8),
    .GOAL_LEVEL_3         (12),
    .MAX_LEVEL            (3)
  ) dut (
    .SC_LEVEL_PROGRESS_CLOCK_50    (clk),
    .SC_LEVEL_PROGRESS_RESET_InHigh(rst),
    .bus                           (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int lvl, input int cnt, input int gr);
    chk({tag, ".level"}, int'(bus.SC_LEVEL_PROGRESS_CurrentLevel_Out), lvl);
    chk({tag, ".count"}, int'(bus.SC_LEVEL_PROGRESS_LvlProgressCount_Out), cnt);
    chk({tag, ".goal"},  int'(bus.SC_LEVEL_PROGRESS_GoalReached_Out), gr);
  endtask

  // One crossing: one cycle low, two cycles high.
  task automatic pulse();
    bus.SC_LEVEL_PROGRESS_FrogArrived_InLow = 1'b0;
    tick();
    bus.SC_LEVEL_PROGRESS_FrogArrived_InLow = 1'b1;
    tick();
    tick();
  endtask

  task automatic finish_level();
    bus.SC_LEVEL_PROGRESS_LevelFinished_In = 1'b1;
    tick();
    bus.SC_LEVEL_PROGRESS_LevelFinished_In = 1'b0;
    tick();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.SC_LEVEL_PROGRESS_FrogArrived_InLow = 1'b1;
    bus.SC_LEVEL_PROGRESS_StartCount_In     = 1'b0;
    bus.SC_LEVEL_PROGRESS_LevelFinished_In  = 1'b0;
    bus.SC_LEVEL_PROGRESS_FinishedGame_In   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk_out("reset", 0, 0, 0);

    // IDLE holds while StartCount is low, even with crossings.
    pulse();
    chk_out("idle_hold", 0, 0, 0);

    // Level 1.
    bus.SC_LEVEL_PROGRESS_StartCount_In = 1'b1;
    tick();
    chk_out("start_l1", 1, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      bus.SC_LEVEL_PROGRESS_FrogArrived_InLow = 1'b0;
      tick();
      chk("l1_step.count", int'(bus.SC_LEVEL_PROGRESS_LvlProgressCount_Out), i);
      chk("l1_step.goal", int'(bus.SC_LEVEL_PROGRESS_GoalReached_Out), (i == 5) ? 1 : 0);
      bus.SC_LEVEL_PROGRESS_FrogArrived_InLow = 1'b1;
      tick();
      tick();
    end
    for (int i = 0; i < 3; i++) pulse();
    chk_out("goal_hold", 1, 5, 1);

    // LevelFinished: ADVANCE then IDLE with level 2, then COUNTING.
    bus.SC_LEVEL_PROGRESS_LevelFinished_In = 1'b1;
    tick();
    bus.SC_LEVEL_PROGRESS_LevelFinished_In = 1'b0;
    chk_out("advance_cycle", 1, 5, 1);
    tick();
    chk_out("adv_l2", 2, 0, 0);
    tick();
    chk_out("counting_l2", 2, 0, 0);

    // Held-low input produces a single count.
    bus.SC_LEVEL_PROGRESS_FrogArrived_InLow = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    bus.SC_LEVEL_PROGRESS_FrogArrived_InLow = 1'b1;
    tick();
    chk_out("held_low", 2, 1, 0);
    for (int i = 0; i < 7; i++) pulse();
    chk_out("goal_l2", 2, 8, 1);
    finish_level();
    chk_out("adv_l3", 3, 0, 0);
    tick();

    // Level 3 then endgame.
    for (int i = 0; i < 11; i++) pulse();
    chk_out("l3_pre_goal", 3, 11, 0);
    pulse();
    chk_out("goal_l3", 3, 12, 1);
    finish_level();
    chk_out("endgame", 4, 0, 0);
    for (int i = 0; i < 3; i++) pulse();
    bus.SC_LEVEL_PROGRESS_StartCount_In = 1'b0;
    tick();
    bus.SC_LEVEL_PROGRESS_StartCount_In = 1'b1;
    tick();
    pulse();
    chk_out("frozen_hold", 4, 0, 0);

    // FinishedGame mid-level with a coincident crossing.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_out("reset2", 0, 0, 0);
    tick();
    chk_out("restart_l1", 1, 0, 0);
    for (int i = 0; i < 3; i++) pulse();
    chk_out("mid_l1", 1, 3, 0);
    bus.SC_LEVEL_PROGRESS_FinishedGame_In   = 1'b1;
    bus.SC_LEVEL_PROGRESS_FrogArrived_InLow = 1'b0;
    tick();
    bus.SC_LEVEL_PROGRESS_FinishedGame_In   = 1'b0;
    bus.SC_LEVEL_PROGRESS_FrogArrived_InLow = 1'b1;
    chk_out("fg_edge", 1, 3, 0);
    for (int i = 0; i < 2; i++) pulse();
    bus.SC_LEVEL_PROGRESS_StartCount_In = 1'b0;
    tick();
    bus.SC_LEVEL_PROGRESS_StartCount_In = 1'b1;
    tick();
    chk_out("fg_frozen", 1, 3, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_out("reset3", 0, 0, 0);

    // StartCount drop concurrent with a crossing.
    tick();
    chk_out("restart2_l1", 1, 0, 0);
    for (int i = 0; i < 2; i++) pulse();
    chk_out("pre_drop", 1, 2, 0);
    bus.SC_LEVEL_PROGRESS_StartCount_In     = 1'b0;
    bus.SC_LEVEL_PROGRESS_FrogArrived_InLow = 1'b0;
    tick();
    bus.SC_LEVEL_PROGRESS_FrogArrived_InLow = 1'b1;
    chk_out("drop_edge", 1, 2, 0);
    tick();
    pulse();
    chk_out("idle_after_drop", 1, 2, 0);
    bus.SC_LEVEL_PROGRESS_StartCount_In = 1'b1;
    tick();
    chk_out("reraise", 1, 0, 0);
    pulse();
    chk_out("recount", 1, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sc_level_progress_tracker.md
# sc_level_progress_tracker

Produces the current level number and per-level progress count that the Frogger level state machine consumes. Counts frog crossings (active-low arrival pulses from the playfield logic) while counting is enabled, and flags when the level goal is reached. Advances the level on the state machine's LevelFinished request, and freezes on game end. It sits between the playfield/collision logic and the level state machine: this block drives CurrentLevel/LvlProgressCount to the state machine, and the state machine drives StartCount/LevelFinished/FinishedGame back to this block.

## Interface
- CURRENT_LEVEDATAWIDTH, 3, width of level number
- PROGRESS_DATAWIDTH, 5, width of progress count
- GOAL_LEVEL_1, 5, crossings required in level 1
- GOAL_LEVEL_2, 8, crossings required in level 2
- GOAL_LEVEL_3, 12, crossings required in level 3
- MAX_LEVEL, 3, last playable level
- SC_LEVEL_PROGRESS_CLOCK_50  in  1  system clock, 50 MHz
- SC_LEVEL_PROGRESS_RESET_InHigh  in  1  one clock; reset is synchronous and active-high
- SC_LEVEL_PROGRESS_FrogArrived_InLow  in  1  low level = frog at goal row; 1→0 transition = one crossing
- SC_LEVEL_PROGRESS_StartCount_In  in  1  high = counting enabled
- SC_LEVEL_PROGRESS_LevelFinished_In  in  1  high = advance-level request
- SC_LEVEL_PROGRESS_FinishedGame_In  in  1  high = freeze all outputs
- SC_LEVEL_PROGRESS_CurrentLevel_Out  out  CURRENT_LEVEDATAWIDTH  0 = no level, 1..3 = playing, 4 = endgame
- SC_LEVEL_PROGRESS_LvlProgressCount_Out  out  PROGRESS_DATAWIDTH  crossings in current level
- SC_LEVEL_PROGRESS_GoalReached_Out  out  1  high while count equals the current level's goal

## Operation
- All outputs are registered. Reset values: CurrentLevel=0, LvlProgressCount=0, GoalReached=0, state=IDLE, arrival sample register=1.
- Edge detect:
  - Arrival register samples FrogArrived_InLow every cycle.
  - edge = (register==1) && (input==0).
  - Edges are never queued; any edge not consumed in the cycle it occurs is dropped.
- Goal lookup: level 1/2/3 → GOAL_LEVEL_1/2/3. Any other level value → GOAL_LEVEL_3.
- Priority: reset > FinishedGame > state transitions below.
- FSM states:
  - IDLE(0)
    - StartCount=1 → COUNTING; CurrentLevel←(CurrentLevel==0 ? 1 : CurrentLevel); count←0.
    - StartCount=0 → stay in IDLE and hold all outputs.
  - COUNTING(1)
    - StartCount=0 → IDLE; count held; a same-cycle edge is dropped.
    - Else, on edge: count←count+1, saturating at 2^PROGRESS_DATAWIDTH−1.
    - If the new count equals the goal → GOAL, and GoalReached←1 in the same cycle.
    - LevelFinished is ignored in this state.
  - GOAL(2)
    - Count and GoalReached are held; edges are ignored.
    - LevelFinished=1 → ADVANCE.
  - ADVANCE(3): lasts exactly one cycle.
    - count←0 and GoalReached←0.
    - If CurrentLevel==MAX_LEVEL: CurrentLevel←MAX_LEVEL+1 (=4), then → FROZEN.
    - Else: CurrentLevel←CurrentLevel+1, then → IDLE.
  - FROZEN(4): all outputs held; the only exit is reset.
- FinishedGame=1 in any state → FROZEN next cycle with outputs unchanged. A same-cycle edge or advance is discarded.
- Unused state encodings (5–7) → IDLE next cycle.

## Timing
- Arrival latency: FrogArrived_InLow sampled 0 at clock edge N (and 1 at edge N−1) → count updated after edge N, so it is visible in cycle N+1.
- GoalReached rises in the same cycle the count reaches the goal.
- LevelFinished handshake:
  - Sampled high in GOAL at edge N → ADVANCE after N.
  - Level incremented and count cleared after N+1.
  - IDLE after N+1.
  - If StartCount is still high, COUNTING after N+2.
  - LevelFinished may stay high; it has no effect outside GOAL.
- Reset is synchronous: asserted at edge N → all outputs at reset values after N, including mid-ADVANCE or in FROZEN.
- Input held low continuously produces one count only. A new crossing requires the input to return high for ≥1 sampled cycle.

## Test plan
- Reset then StartCount=1 → CurrentLevel=1 and count=0 one cycle later. Then 5 low pulses, each 1 cycle low / 2 cycles high → count steps 1..5 and GoalReached=1 with count=5.
- In GOAL: 3 further pulses → count stays 5. Then LevelFinished=1 for 1 cycle → next cycle count=0, GoalReached=0, CurrentLevel=2.
- FrogArrived_InLow held low for 20 cycles in COUNTING → count increments exactly once.
- Play through levels 2 (8 pulses) and 3 (12 pulses), issuing LevelFinished after each → CurrentLevel=4, state FROZEN; further pulses and StartCount toggles → no output change.
- Mid-level (count=3): FinishedGame=1 concurrent with an edge → count stays 3, outputs frozen. Then reset=1 for one cycle → CurrentLevel=0, count=0, GoalReached=0.
- Mid-level: StartCount drops in the same cycle as an edge → count unchanged, state IDLE. StartCount re-raised → count resets to 0, level unchanged.
